// File: rtl/core_seq_if.sv
// rtl/core_seq_if.sv - sequencer bus: instruction fetch, decoder/ALU/register-file controls, ecall handshake
`ifndef XBUS
`define XBUS 32
`endif
`ifndef PC_MODE_MSB
`define PC_MODE_MSB 0
`define PC_MODE_INC 1'b0
`define PC_MODE_ADD 1'b1
`endif

interface core_seq_if #(parameter int XLEN = `XBUS);
  logic                  imem_req;
  logic [XLEN-1:0]       imem_addr;
  logic                  imem_ack;
  logic [XLEN-1:0]       imem_rdata;
  logic [XLEN-1:0]       inst;
  logic                  dec_exc;
  logic                  dec_is_cond;
  logic [`PC_MODE_MSB:0] dec_pc_mode;
  logic [XLEN-1:0]       dec_pc_update;
  logic                  dec_write_reg;
  logic                  dec_ecall;
  logic [XLEN-1:0]       alu_res;
  logic                  rf_we;
  logic                  ecall_req;
  logic                  ecall_ack;

  modport master (
    output imem_req, imem_addr, inst, rf_we, ecall_req,
    input  imem_ack, imem_rdata, dec_exc, dec_is_cond, dec_pc_mode, dec_pc_update,
           dec_write_reg, dec_ecall, alu_res, ecall_ack
  );

  modport slave (
    input  imem_req, imem_addr, inst, rf_we, ecall_req,
    output imem_ack, imem_rdata, dec_exc, dec_is_cond, dec_pc_mode, dec_pc_update,
           dec_write_reg, dec_ecall, alu_res, ecall_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - RV32I multi-cycle control FSM: fetch, decode, exec, writeback, ecall, trap
// Optional SEQ_RETIRE_CNT_EN adds a 64-bit retired-instruction counter output (instret).
`ifndef XBUS
`define XBUS 32
`endif
`ifndef PC_MODE_MSB
`define PC_MODE_MSB 0
`define PC_MODE_INC 1'b0
`define PC_MODE_ADD 1'b1
`endif

module core_sequencer #(
  parameter int              XLEN          = `XBUS,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  core_seq_if.master      bus,
  output logic [XLEN-1:0] pc,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic            retire
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_ECALL  = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;
  localparam int         CW       = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

  logic [2:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target;
  logic            take;
  logic            req_q;
  logic            rf_we_q;
  logic            ecall_req_q;
  logic            fetch_done;
  logic            timeout_hit;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;
  assign bus.inst      = inst_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.ecall_req = ecall_req_q;

  always_comb begin
    take   = (bus.dec_pc_mode == `PC_MODE_ADD) && (!bus.dec_is_cond || bus.alu_res[0]);
    target = pc + (take ? bus.dec_pc_update : XLEN'(4));
  end

  // Only acks seen while the request is up count; the ack beats a same-cycle timeout.
  assign fetch_done  = req_q && bus.imem_ack;
  assign timeout_hit = (FETCH_TIMEOUT != 0) && req_q && !bus.imem_ack &&
                       (int'(wait_cnt) == FETCH_TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      next_pc     <= RESET_PC;
      inst_q      <= XLEN'(32'h0000_0013);
      req_q       <= 1'b0;
      rf_we_q     <= 1'b0;
      ecall_req_q <= 1'b0;
      trap        <= 1'b0;
      trap_cause  <= 2'd0;
      retire      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rf_we_q <= 1'b0;
      retire  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (fetch_done) begin
            inst_q   <= bus.imem_rdata;
            req_q    <= 1'b0;
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (timeout_hit) begin
            req_q      <= 1'b0;
            wait_cnt   <= '0;
            trap       <= 1'b1;
            trap_cause <= 2'd3;
            state      <= S_TRAP;
          end else begin
            req_q <= 1'b1;
            if (req_q) wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (bus.dec_exc) begin
            trap       <= 1'b1;
            trap_cause <= 2'd1;
            state      <= S_TRAP;
          end else if (bus.dec_ecall) begin
            ecall_req_q <= 1'b1;
            state       <= S_ECALL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (target[1:0] != 2'b00) begin
            trap       <= 1'b1;
            trap_cause <= 2'd2;
            state      <= S_TRAP;
          end else begin
            next_pc <= target;
            rf_we_q <= bus.dec_write_reg;
            retire  <= 1'b1;
            state   <= S_WB;
          end
        end
        S_WB: begin
          pc    <= next_pc;
          state <= S_FETCH;
        end
        S_ECALL: begin
          if (ecall_req_q && bus.ecall_ack) begin
            ecall_req_q <= 1'b0;
            pc          <= pc + XLEN'(4);
            retire      <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (retire && (state != S_TRAP)) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized bench for core_sequencer with a per-instruction timing model
`ifndef XBUS
`define XBUS 32
`endif
`ifndef PC_MODE_MSB
`define PC_MODE_MSB 0
`define PC_MODE_INC 1'b0
`define PC_MODE_ADD 1'b1
`endif

module tb_core_sequencer;
  localparam int          FT       = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [`PC_MODE_MSB:0] M_INC = `PC_MODE_INC;
  localparam logic [`PC_MODE_MSB:0] M_ADD = `PC_MODE_ADD;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        retire;
`ifdef SEQ_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  core_seq_if #(.XLEN(32)) bus ();

  core_sequencer #(.XLEN(32), .RESET_PC(RESET_PC), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pc(pc), .trap(trap),
    .trap_cause(trap_cause), .retire(retire)
`ifdef SEQ_RETIRE_CNT_EN
    , .instret(instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle, scheduled by the driver from the latency rules.
  logic        e_req, e_rf_we, e_retire, e_ecall_req, e_trap;
  logic [1:0]  e_cause;
  logic [31:0] e_pc, e_inst;
  logic [63:0] e_instret;

  int cyc, first_ret, rfwe_cnt, retire_cnt;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", bus.imem_req, e_req);
      check("imem_addr", bus.imem_addr, e_pc);
      check("pc", pc, e_pc);
      check("inst", bus.inst, e_inst);
      check("rf_we", bus.rf_we, e_rf_we);
      check("retire", retire, e_retire);
      check("ecall_req", bus.ecall_req, e_ecall_req);
      check("trap", trap, e_trap);
      check("trap_cause", trap_cause, e_cause);
`ifdef SEQ_RETIRE_CNT_EN
      check("instret", instret, e_instret);
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (retire && first_ret == 0) first_ret = cyc;
      if (retire) retire_cnt++;
      if (bus.rf_we) rfwe_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (e_retire) e_instret = e_instret + 64'd1;
    e_retire = 1'b0;
    e_rf_we  = 1'b0;
  endtask

  task automatic dec_noise();
    bus.dec_exc       = rbit();
    bus.dec_ecall     = rbit();
    bus.dec_is_cond   = rbit();
    bus.dec_pc_mode   = (`PC_MODE_MSB+1)'($urandom);
    bus.dec_pc_update = $urandom;
    bus.dec_write_reg = rbit();
    bus.alu_res       = $urandom;
  endtask

  task automatic ack_noise();
    bus.imem_ack   = rbit();
    bus.imem_rdata = $urandom;
    bus.ecall_ack  = rbit();
  endtask

  // Called half-way into a cycle; the reset values must appear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    e_req = 1'b0; e_rf_we = 1'b0; e_retire = 1'b0; e_ecall_req = 1'b0;
    e_trap = 1'b0; e_cause = 2'd0; e_pc = RESET_PC; e_inst = NOP; e_instret = 64'd0;
    bus.imem_ack = 1'b0;
    bus.ecall_ack = 1'b0;
    #2;
    check("async_rst_imem_req", bus.imem_req, 1'b0);
    check("async_rst_ecall_req", bus.ecall_req, 1'b0);
    check("async_rst_pc", pc, RESET_PC);
    step();
    step();
    rst = 1'b0;
    cyc = 0; first_ret = 0; rfwe_cnt = 0; retire_cnt = 0;
  endtask

  task automatic hold_trap();
    repeat (3) begin
      step();
      ack_noise();
      dec_noise();
    end
  endtask

  // Runs one instruction starting in the first FETCH cycle (request still low).
  // outcome: 0 retired, 1 trapped, 2 reset applied mid-instruction.
  task automatic one_instr(input int d, input logic [31:0] word, input logic exc, input logic ecl,
                           input logic cond, input logic [`PC_MODE_MSB:0] mode, input logic [31:0] upd,
                           input logic [31:0] alu, input logic wr, input int w, input int rst_at,
                           output int outcome);
    logic [31:0] target;
    logic        take;
    outcome = 0;
    for (int i = 0; i <= d; i++) begin
      step();
      dec_noise();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      bus.ecall_ack  = rbit();
      if (i == FT) begin
        e_req = 1'b0; e_trap = 1'b1; e_cause = 2'd3;
        outcome = 1;
        return;
      end
      e_req = 1'b1;
      if (rst_at == 1 && i == 1) begin
        do_reset();
        outcome = 2;
        return;
      end
      if (i == d) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
      end
    end
    step();
    ack_noise();
    e_req = 1'b0;
    e_inst = word;
    bus.dec_exc = exc; bus.dec_ecall = ecl; bus.dec_is_cond = cond; bus.dec_pc_mode = mode;
    bus.dec_pc_update = upd; bus.alu_res = alu; bus.dec_write_reg = wr;
    if (exc) begin
      step();
      ack_noise();
      e_trap = 1'b1; e_cause = 2'd1;
      outcome = 1;
      return;
    end
    if (ecl) begin
      step();
      bus.imem_ack = rbit();
      bus.ecall_ack = 1'b0;
      e_ecall_req = 1'b1;
      for (int j = 0; j < w; j++) begin
        if (rst_at == 2 && j == 1) begin
          do_reset();
          outcome = 2;
          return;
        end
        step();
        bus.imem_ack = rbit();
        bus.ecall_ack = 1'b0;
      end
      bus.ecall_ack = 1'b1;
      step();
      bus.ecall_ack = 1'b0;
      bus.imem_ack = 1'b0;
      e_ecall_req = 1'b0;
      e_pc = e_pc + 32'd4;
      e_retire = 1'b1;
      return;
    end
    take   = (mode == M_ADD) && (!cond || alu[0]);
    target = e_pc + (take ? upd : 32'd4);
    step();
    ack_noise();
    step();
    ack_noise();
    if (target[1:0] != 2'b00) begin
      e_trap = 1'b1; e_cause = 2'd2;
      outcome = 1;
      return;
    end
    e_rf_we = wr;
    e_retire = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    e_pc = target;
  endtask

  int          o, d, w, r, rst_at;
  logic        exc, ecl, cond, wr;
  logic [31:0] upd, word;
  logic [`PC_MODE_MSB:0] mode;

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.ecall_ack = 1'b0;
    bus.dec_exc = 1'b0; bus.dec_ecall = 1'b0; bus.dec_is_cond = 1'b0; bus.dec_pc_mode = M_INC;
    bus.dec_pc_update = '0; bus.dec_write_reg = 1'b0; bus.alu_res = '0;
    step();
    chk_en = 1'b1;
    do_reset();

    one_instr(0, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h5, 1, 0, 0, o);
    check("first_retire_cycle", 64'(first_ret), 64'd5);
    check("pc_after_addi", pc, 32'd4);
    check("rf_we_pulses_addi", 64'(rfwe_cnt), 64'd1);
    one_instr(0, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h5, 1, 0, 0, o);
    one_instr(0, 32'hfe20_8ee3, 0, 0, 1, M_ADD, 32'hFFFF_FFFC, 32'h1, 0, 0, 0, o);
    check("beq_taken_pc", pc, 32'd4);
    check("beq_taken_rf_we", 64'(rfwe_cnt), 64'd2);
`ifdef SEQ_RETIRE_CNT_EN
    check("instret_three", instret, 64'd3);
`endif
    one_instr(1, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h5, 1, 0, 0, o);
    one_instr(2, 32'hfe20_8ee3, 0, 0, 1, M_ADD, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, o);
    check("beq_not_taken_pc", pc, 32'd12);
    check("beq_not_taken_rf_we", 64'(rfwe_cnt), 64'd3);
    one_instr(0, 32'h0000_0073, 0, 1, 0, M_INC, 0, 32'h0, 0, 3, 0, o);
    check("ecall_pc", pc, 32'd16);

    do_reset();
    one_instr(0, 32'h4084_90b3, 1, 0, 0, M_INC, 0, 32'h0, 1, 0, 0, o);
    check("illegal_trap", trap, 1'b1);
    check("illegal_cause", trap_cause, 2'd1);
    check("illegal_no_retire", 64'(retire_cnt), 64'd0);
    check("illegal_no_rf_we", 64'(rfwe_cnt), 64'd0);
    hold_trap();
    do_reset();
    one_instr(0, 32'h0020_0063, 0, 0, 0, M_ADD, 32'd2, 32'h0, 0, 0, 0, o);
    check("misaligned_cause", trap_cause, 2'd2);
    check("misaligned_pc", pc, RESET_PC);
    hold_trap();
    do_reset();
    one_instr(10, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h0, 1, 0, 0, o);
    check("timeout_cause", trap_cause, 2'd3);
    hold_trap();
    do_reset();
    one_instr(FT - 1, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h0, 1, 0, 0, o);
    check("late_ack_no_trap", trap, 1'b0);
    check("late_ack_pc", pc, 32'd4);
    one_instr(0, 32'h0000_0073, 0, 1, 0, M_INC, 0, 32'h0, 0, 3, 2, o);
    check("rst_in_ecall_pc", pc, RESET_PC);
    one_instr(3, 32'h0011_0093, 0, 0, 0, M_INC, 0, 32'h0, 1, 0, 1, o);
    check("rst_in_fetch_req", bus.imem_req, 1'b0);

    for (int n = 0; n < 300; n++) begin
      d      = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      exc    = ($urandom_range(0, 19) == 0);
      ecl    = ($urandom_range(0, 7) == 0);
      cond   = rbit();
      mode   = (`PC_MODE_MSB+1)'($urandom);
      upd    = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h2) : ($urandom & 32'hFFFF_FFFC);
      word   = $urandom;
      wr     = rbit();
      w      = $urandom_range(0, 3);
      r      = $urandom_range(0, 29);
      rst_at = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      one_instr(d, word, exc, ecl, cond, mode, upd, $urandom, wr, w, rst_at, o);
      if (o == 1) begin
        hold_trap();
        do_reset();
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It fetches an instruction over a req/ack instruction-memory handshake and holds it steady for the combinational Decoder. It then sequences register read, ALU evaluation, register writeback and PC update, and diverts to ecall or trap handling. It owns the architectural PC and is the only block that sequences Decoder, register file and ALU.

Parameters:
XLEN, 32, data/address width; must equal the `XBUS width
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 255, max cycles waiting for imem_ack before bus-error trap; 0 disables the timeout

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  XLEN  fetch address (= pc)
imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  in  XLEN  fetched instruction
inst  out  XLEN  latched instruction, to Decoder.inst
dec_exc  in  1  Decoder illegal-instruction flag
dec_is_cond  in  1  conditional branch
dec_pc_mode  in  `PC_MODE_MSB+1  `PC_MODE_INC or `PC_MODE_ADD
dec_pc_update  in  XLEN  branch offset
dec_write_reg  in  1  Decoder act_write_reg
dec_ecall  in  1  Decoder act_ecall
alu_res  in  XLEN  ALU result; bit 0 is the branch condition when dec_is_cond=1
rf_we  out  1  register-file write enable, one-cycle pulse
pc  out  XLEN  current PC
ecall_req  out  1  ecall service request
ecall_ack  in  1  ecall service complete
trap  out  1  sticky; core halted on exception
trap_cause  out  2  0 none, 1 illegal instr, 2 misaligned target, 3 fetch timeout
retire  out  1  one-cycle pulse per retired instruction

Behaviour:
- Reset (async, rst=1): state=FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), imem_req=0, rf_we=0, ecall_req=0, trap=0, trap_cause=0, retire=0, timeout counter=0.
- States: FETCH, DECODE, EXEC, WB, ECALL, TRAP.
- FETCH: imem_req=1, imem_addr=pc, counter increments each cycle.
  - If imem_ack: latch inst<=imem_rdata, drop imem_req, go to DECODE.
  - If the counter reaches FETCH_TIMEOUT with no ack (FETCH_TIMEOUT>0): go to TRAP with cause 3.
  - imem_req is registered: it is low in the cycle after imem_ack.
- DECODE: one settle cycle for the Decoder and register-file read.
  - dec_exc=1 -> TRAP, cause 1.
  - Else dec_ecall=1 -> ECALL.
  - Else -> EXEC.
- EXEC: one cycle for the ALU to settle.
  - Compute next_pc = pc+pc_update when dec_pc_mode=`PC_MODE_ADD and (!dec_is_cond or alu_res[0]); otherwise pc+4.
  - Addition is modulo 2^XLEN; wrap-around is legal.
  - next_pc[1:0]!=0 -> TRAP, cause 2; pc is left unchanged.
  - Else -> WB.
- WB: rf_we=dec_write_reg for exactly this one cycle; pc<=next_pc; retire=1; -> FETCH.
  - Writes to x0 are pulsed anyway; the register file ignores them.
- ECALL: ecall_req=1 (registered) until ecall_ack is sampled high.
  - Then pc<=pc+4, retire=1, ecall_req drops next cycle, -> FETCH.
  - Decoder presents rs1=x10 throughout, so the handler reads a0 via the register file.
- TRAP: trap=1, trap_cause held; all strobes low. Only rst leaves TRAP.
- Latency: non-ecall instruction = fetch wait + 4 cycles (ack cycle, DECODE, EXEC, WB). With an ack one cycle after req, the first retire is at cycle 5 after reset release.
- inst changes only on the imem_ack cycle in FETCH, so Decoder outputs are stable from DECODE through WB.
- Simultaneous events:
  - imem_ack on the same edge as the timeout: the ack wins.
  - ecall_ack asserted before ecall_req: ignored.
  - imem_ack outside FETCH: ignored.
- Reset mid-operation, any state: immediate return to the reset values; an in-flight imem_req is abandoned, and the memory must tolerate this.

Optional Feature:
Macro SEQ_RETIRE_CNT_EN.
- When defined: adds output instret (64 bits).
  - Reset value 0; increments on every retire pulse; wraps modulo 2^64.
  - Frozen in TRAP.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, memory acks next cycle, inst=addi x1,x2,1 (0x00110093) -> imem_addr=0; rf_we high exactly one cycle in WB; pc=4 after WB; retire at cycle 5.
- beq x1,x2,-4 (0xfe208ee3) at pc=8: alu_res=1 -> pc=4; alu_res=0 -> pc=12; rf_we=0 in both cases.
- Illegal sll with bit30 set (0x408490b3), dec_exc=1 -> trap=1, trap_cause=1 two cycles after ack; no rf_we, no retire; imem_req stays low.
- Branch with dec_pc_update=2 taken -> trap_cause=2; pc unchanged. Separately, FETCH_TIMEOUT=4 with no ack -> trap_cause=3 after 4 cycles; ack arriving on cycle 4 instead -> DECODE, no trap.
- ecall (0x00000073) -> ecall_req held through 3 wait cycles; ecall_ack -> pc+=4, retire=1, ecall_req low the next cycle.
- Assert rst during ECALL and during FETCH -> all outputs at reset values immediately (asynchronously); with SEQ_RETIRE_CNT_EN, instret=0 after reset and instret=3 after three retirements.
